mem_port_arbiter: RTL and testbench

//  Shares the single-port RAM between the control unit's instruction-fetch path and its

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port RAM between the instruction-fetch path
//                and the load/store data path; fair tie-break, registered
//                RAM strobes and a one-cycle ack per completed access.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic c_ID_IF = 1'b0;
    localparam logic c_ID_LS = 1'b1;
    localparam int   c_CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(RD_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t              r_state,      w_state_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                r_gnt,        w_gnt_nxt;
    logic                r_we,         w_we_nxt;
    logic [c_CNT_W-1:0]  r_cnt,        w_cnt_nxt;
    logic                r_if_ack,     w_if_ack_nxt;
    logic                r_ls_ack,     w_ls_ack_nxt;
    logic [DATA_W-1:0]   r_if_rdata,   w_if_rdata_nxt;
    logic [DATA_W-1:0]   r_ls_rdata,   w_ls_rdata_nxt;
    logic [ADDR_W-1:0]   r_ram_addr,   w_ram_addr_nxt;
    logic [DATA_W-1:0]   r_ram_wdata,  w_ram_wdata_nxt;
    logic                r_ram_read,   w_ram_read_nxt;
    logic                r_ram_write,  w_ram_write_nxt;
    logic                r_busy,       w_busy_nxt;

    logic                w_grant_id;
    logic                w_store;

    // On a tie the requester that did not win last time is served.
    assign w_grant_id = (if_req && ls_req) ? ~r_last_grant : ls_req;
    assign w_store    = (w_grant_id == c_ID_LS) && ls_we;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_last_grant <= c_ID_IF;
            r_gnt        <= c_ID_IF;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_if_ack     <= 1'b0;
            r_ls_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_read   <= 1'b0;
            r_ram_write  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_gnt        <= w_gnt_nxt;
            r_we         <= w_we_nxt;
            r_cnt        <= w_cnt_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_ls_ack     <= w_ls_ack_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_ls_rdata   <= w_ls_rdata_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_wdata  <= w_ram_wdata_nxt;
            r_ram_read   <= w_ram_read_nxt;
            r_ram_write  <= w_ram_write_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_gnt_nxt        = r_gnt;
        w_we_nxt         = r_we;
        w_cnt_nxt        = r_cnt;
        w_if_ack_nxt     = 1'b0;
        w_ls_ack_nxt     = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_ls_rdata_nxt   = r_ls_rdata;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_wdata_nxt  = r_ram_wdata;
        w_ram_read_nxt   = r_ram_read;
        w_ram_write_nxt  = r_ram_write;
        w_busy_nxt       = r_busy;

        case (r_state)
            IDLE: begin
                if (if_req || ls_req) begin
                    w_state_nxt      = ACCESS;
                    w_last_grant_nxt = w_grant_id;
                    w_gnt_nxt        = w_grant_id;
                    w_we_nxt         = w_store;
                    w_cnt_nxt        = c_CNT_INIT;
                    w_ram_addr_nxt   = (w_grant_id == c_ID_LS) ? ls_addr : if_addr;
                    w_ram_wdata_nxt  = w_store ? ls_wdata : r_ram_wdata;
                    w_ram_read_nxt   = ~w_store;
                    w_ram_write_nxt  = w_store;
                    w_busy_nxt       = 1'b1;
                end
            end

            ACCESS: begin
                if (r_we) begin
                    w_ram_write_nxt = 1'b0;
                    w_ls_ack_nxt    = 1'b1;
                    w_state_nxt     = RESP;
                end else if (r_cnt == '0) begin
                    // Last read cycle: RAM data is valid at this edge.
                    w_ram_read_nxt = 1'b0;
                    w_state_nxt    = RESP;
                    if (r_gnt == c_ID_LS) begin
                        w_ls_rdata_nxt = ram_rdata;
                        w_ls_ack_nxt   = 1'b1;
                    end else begin
                        w_if_rdata_nxt = ram_rdata;
                        w_if_ack_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            RESP: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt     = IDLE;
                w_ram_read_nxt  = 1'b0;
                w_ram_write_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    assign if_ack    = r_if_ack;
    assign if_rdata  = r_if_rdata;
    assign ls_ack    = r_ls_ack;
    assign ls_rdata  = r_ls_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_read  = r_ram_read;
    assign ram_write = r_ram_write;
    assign busy      = r_busy;

    a_no_rw_overlap: assert property (@(posedge clk) disable iff (!Reset)
        !(ram_read && ram_write));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter with behavioural RAMs
//                at read latency 1 (main instance) and 3 (second instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic Reset;

    logic          if_req, ls_req, ls_we, if_ack, ls_ack, ram_read, ram_write, busy;
    logic [AW-1:0] if_addr, ls_addr, ram_addr;
    logic [DW-1:0] ls_wdata, if_rdata, ls_rdata, ram_wdata, ram_rdata;

    logic          b_if_req, b_ls_req, b_ls_we, b_if_ack, b_ls_ack, b_ram_read, b_ram_write, b_busy;
    logic [AW-1:0] b_if_addr, b_ls_addr, b_ram_addr;
    logic [DW-1:0] b_ls_wdata, b_if_rdata, b_ls_rdata, b_ram_wdata, b_ram_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A)) u_dut (
        .clk(clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_read(ram_read),
        .ram_write(ram_write), .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B)) u_dut3 (
        .clk(clk), .Reset(Reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
        .ls_ack(b_ls_ack), .ls_rdata(b_ls_rdata),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_read(b_ram_read),
        .ram_write(b_ram_write), .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    // Behavioural RAMs: data is only presented in the final cycle of a read
    // burst, so a wrong read length captures garbage.
    logic [DW-1:0] mem_a [0:511];
    logic [DW-1:0] mem_b [0:511];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    int            rd_cnt_a, rd_cnt_b;

    always @(posedge clk) begin
        if (pre_we) begin
            mem_a[pre_addr] <= pre_data;
            mem_b[pre_addr] <= pre_data;
        end else begin
            if (ram_write)   mem_a[ram_addr]   <= ram_wdata;
            if (b_ram_write) mem_b[b_ram_addr] <= b_ram_wdata;
        end
        rd_cnt_a <= ram_read   ? rd_cnt_a + 1 : 0;
        rd_cnt_b <= b_ram_read ? rd_cnt_b + 1 : 0;
    end

    assign ram_rdata   = (ram_read   && rd_cnt_a == LAT_A-1) ? mem_a[ram_addr]   : 32'hDEAD_DEAD;
    assign b_ram_rdata = (b_ram_read && rd_cnt_b == LAT_B-1) ? mem_b[b_ram_addr] : 32'hDEAD_DEAD;

    typedef struct {
        logic          who;   // 0 = IF, 1 = LS
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_req   = 1'($urandom);
            ls_req   = 1'($urandom);
            ls_we    = 1'($urandom);
            if_addr  = AW'($urandom);
            ls_addr  = AW'($urandom);
            ls_wdata = $urandom;
            tick();
            checks++;
            if ({if_ack, ls_ack, ram_read, ram_write, busy, if_rdata, ls_rdata, ram_addr, ram_wdata} !== '0) begin
                fails++;
                $display("FAIL reset_outputs: got ack=%b%b rd=%b wr=%b busy=%b addr=%h, required all zero",
                         if_ack, ls_ack, ram_read, ram_write, busy, ram_addr);
            end
        end
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        Reset  = 1'b1;
        repeat (3) tick();
        checks++;
        if ({if_ack, ls_ack, ram_read, ram_write, busy, b_busy} !== 6'b0) begin
            fails++;
            $display("FAIL reset_release_idle: got ack=%b%b rd=%b wr=%b busy=%b/%b, required all zero",
                     if_ack, ls_ack, ram_read, ram_write, busy, b_busy);
        end
    endtask

    task automatic test_fetch();
        preload(9'h005, 32'h1234ABCD);
        if_addr = 9'h005;
        if_req  = 1'b1;
        sb.push_back('{1'b0, 1'b0, 32'h1234ABCD});
        tick();                                         // cycle 1
        if_addr = 9'h007;                               // post-grant change must be ignored
        checks++;
        if ({ram_read, ram_write, busy, if_ack, ram_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 9'h005}) begin
            fails++;
            $display("FAIL fetch_cycle1: got rd=%b wr=%b busy=%b ack=%b addr=%h, required rd=1 wr=0 busy=1 ack=0 addr=005",
                     ram_read, ram_write, busy, if_ack, ram_addr);
        end
        tick();                                         // cycle 2
        checks++;
        if ({if_ack, ls_ack, ram_read} !== 3'b100) begin
            fails++;
            $display("FAIL fetch_ack_cycle2: got if_ack=%b ls_ack=%b rd=%b, required 1 0 0", if_ack, ls_ack, ram_read);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (if_rdata !== e.data) begin
                fails++;
                $display("FAIL fetch_rdata: got %h, required %h", if_rdata, e.data);
            end
        end
        if_req = 1'b0;
        tick();                                         // cycle 3
        checks++;
        if ({busy, if_ack, ram_read} !== 3'b000) begin
            fails++;
            $display("FAIL fetch_cycle3_idle: got busy=%b ack=%b rd=%b, required 0 0 0", busy, if_ack, ram_read);
        end
        repeat (2) tick();
        checks++;
        if (if_rdata !== 32'h1234ABCD) begin
            fails++;
            $display("FAIL fetch_rdata_hold: got %h, required 1234abcd", if_rdata);
        end
    endtask

    task automatic test_store_load();
        int  wr_cycles;
        int  rd_cycles;
        logic got;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 9'h010; ls_wdata = 32'h0000BEEF;
        sb.push_back('{1'b1, 1'b1, 32'h0});
        wr_cycles = 0; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (c == 0) ls_wdata = 32'hFFFF_FFFF;
            if (ram_write) begin
                wr_cycles++;
                checks++;
                if ({ram_addr, ram_wdata, ram_read} !== {9'h010, 32'h0000BEEF, 1'b0}) begin
                    fails++;
                    $display("FAIL store_strobe: got addr=%h wdata=%h rd=%b, required 010 0000beef 0",
                             ram_addr, ram_wdata, ram_read);
                end
            end
            if (ls_ack || if_ack) begin
                got = 1'b1;
                ls_req = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL store_ack_unexpected: got ack with empty scoreboard, required none");
                end else begin
                    e = sb.pop_front();
                    if ({if_ack, ls_ack} !== {~e.who, e.who}) begin
                        fails++;
                        $display("FAIL store_ack_port: got if_ack=%b ls_ack=%b, required ls_ack", if_ack, ls_ack);
                    end
                end
            end
        end
        checks++;
        if (!got || wr_cycles != 1) begin
            fails++;
            $display("FAIL store_write_cycles: got ack=%b writes=%0d, required ack=1 writes=1", got, wr_cycles);
        end

        tick();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 9'h010;
        sb.push_back('{1'b1, 1'b0, 32'h0000BEEF});
        got = 1'b0; rd_cycles = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (ram_read) rd_cycles++;
            checks++;
            if (ram_write) begin
                fails++;
                $display("FAIL load_write_strobe: got ram_write=1 rd=%b, required ram_write=0", ram_read);
            end
            if (ls_ack) begin
                got = 1'b1;
                ls_req = 1'b0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (ls_rdata !== e.data) begin
                        fails++;
                        $display("FAIL load_rdata: got %h, required %h", ls_rdata, e.data);
                    end
                end
            end
        end
        checks++;
        if (!got || rd_cycles != LAT_A) begin
            fails++;
            $display("FAIL load_done: got ack=%b read_cycles=%0d, required ack=1 read_cycles=%0d", got, rd_cycles, LAT_A);
        end
        tick();
    endtask

    task automatic test_arbitration();
        int   acks;
        logic rearm_if, rearm_ls, stray;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        preload(9'h020, 32'hA0A0_0001);
        preload(9'h030, 32'hB0B0_0002);
        if_addr = 9'h020; ls_addr = 9'h030; ls_we = 1'b0;
        for (int i = 0; i < 6; i++)
            sb.push_back((i % 2 == 0) ? '{1'b1, 1'b0, 32'hB0B0_0002} : '{1'b0, 1'b0, 32'hA0A0_0001});
        if_req = 1'b1; ls_req = 1'b1;
        acks = 0; rearm_if = 1'b0; rearm_ls = 1'b0;
        for (int c = 0; c < 80 && sb.size() != 0; c++) begin
            tick();
            if (rearm_if) begin if_req = 1'b1; rearm_if = 1'b0; end
            if (rearm_ls) begin ls_req = 1'b1; rearm_ls = 1'b0; end
            if (if_ack || ls_ack) begin
                e = sb.pop_front();
                acks++;
                checks++;
                if ({if_ack, ls_ack} !== {~e.who, e.who}) begin
                    fails++;
                    $display("FAIL arb_order_%0d: got if_ack=%b ls_ack=%b, required %s", acks, if_ack, ls_ack,
                             e.who ? "LS" : "IF");
                end
                checks++;
                if ((ls_ack ? ls_rdata : if_rdata) !== e.data) begin
                    fails++;
                    $display("FAIL arb_data_%0d: got %h, required %h", acks, ls_ack ? ls_rdata : if_rdata, e.data);
                end
                if (ls_ack) begin ls_req = 1'b0; rearm_ls = (acks < 5); end
                if (if_ack) begin if_req = 1'b0; rearm_if = (acks < 5); end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL arb_complete: got %0d acks, required 6", acks);
            sb.delete();
        end
        stray = 1'b0;
        repeat (6) begin
            tick();
            if (if_ack || ls_ack || busy) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            fails++;
            $display("FAIL arb_quiet: got activity after last request, required none");
        end
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        logic stray;
        preload(9'h040, 32'h1111_1111);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 9'h040; ls_wdata = 32'h0000_0055;
        tick();                                         // cycle 1: write strobe up
        checks++;
        if (ram_write !== 1'b1) begin
            fails++;
            $display("FAIL midrst_write_up: got ram_write=%b, required 1", ram_write);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({ram_write, ram_read, busy, ls_ack} !== 4'b0) begin
            fails++;
            $display("FAIL midrst_async_drop: got wr=%b rd=%b busy=%b ack=%b, required all 0",
                     ram_write, ram_read, busy, ls_ack);
        end
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        Reset = 1'b1;
        stray = 1'b0;
        repeat (4) begin
            tick();
            if (ls_ack || if_ack || busy || ram_write) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            fails++;
            $display("FAIL midrst_no_ack: got ack/busy/write after reset, required none");
        end
        checks++;
        if (mem_a[9'h040] !== 32'h1111_1111) begin
            fails++;
            $display("FAIL midrst_ram_unmodified: got %h, required 11111111", mem_a[9'h040]);
        end
    endtask

    task automatic test_rd_lat3();
        logic [15:0] rd_mask;
        int          ack_cyc;
        preload(9'h008, 32'hCAFE_F00D);
        b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_addr = 9'h008;
        sb.push_back('{1'b1, 1'b0, 32'hCAFE_F00D});
        rd_mask = '0; ack_cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (b_ram_read) rd_mask[c] = 1'b1;
            if (b_ls_ack && ack_cyc < 0) begin
                ack_cyc  = c;
                b_ls_req = 1'b0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (b_ls_rdata !== e.data) begin
                        fails++;
                        $display("FAIL lat3_rdata: got %h, required %h", b_ls_rdata, e.data);
                    end
                end
            end
        end
        checks++;
        if (rd_mask !== 16'b0000_0000_0000_1110) begin
            fails++;
            $display("FAIL lat3_read_cycles: got mask %b, required read in cycles 1..3", rd_mask);
        end
        checks++;
        if (ack_cyc != LAT_B + 1) begin
            fails++;
            $display("FAIL lat3_ack_cycle: got %0d, required %0d", ack_cyc, LAT_B + 1);
        end
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        Reset = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        b_if_req = 1'b0; b_ls_req = 1'b0; b_ls_we = 1'b0;
        b_if_addr = '0; b_ls_addr = '0; b_ls_wdata = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_arbitration();
        test_reset_mid_store();
        test_rd_lat3();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200us, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
